// File: rtl/stream_wrr_arbiter_pkg.sv
// Shared state encoding and port-index sizing for stream_wrr_arbiter.
package stream_wrr_arbiter_pkg;

  localparam int MaxPorts    = 8;
  localparam int PortIdxBits = $clog2(MaxPorts);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Successor of a port index, wrapping at the configured port count.
  function automatic logic [PortIdxBits-1:0] next_port(input logic [PortIdxBits-1:0] cur,
                                                       input int n);
    return (int'(cur) == n - 1) ? '0 : PortIdxBits'(int'(cur) + 1);
  endfunction

endpackage

// File: rtl/stream_wrr_arbiter_pick.sv
// Round-robin pick: first set request at or after i_start, wrapping; purely combinational.
module rr_priority_pick
  import stream_wrr_arbiter_pkg::*;
#(
  parameter int NumPorts = 4
) (
  input  logic [NumPorts-1:0]    i_req,
  input  logic [PortIdxBits-1:0] i_start,
  output logic                   o_found,
  output logic [PortIdxBits-1:0] o_idx
);

  always_comb begin
    int w_idx;
    o_found = 1'b0;
    o_idx   = '0;
    w_idx   = 0;
    for (int k = 0; k < NumPorts; k++) begin
      w_idx = (int'(i_start) + k) % NumPorts;
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_idx   = PortIdxBits'(w_idx);
      end
    end
  end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin stream merge, zero-latency pass-through; the granted port sees dout_ready, others stall.
// STREAM_WRR_ARBITER_PKT_LOCK_EN: release only at end-of-packet so packets never interleave.
module stream_wrr_arbiter
  import stream_wrr_arbiter_pkg::*;
#(
  parameter int NumPorts   = 4,
  parameter int DataBits   = 32,
  parameter int WeightBits = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumPorts*WeightBits-1:0] weights,
  input  logic [NumPorts-1:0]            din_valid,
  output logic [NumPorts-1:0]            din_ready,
  input  logic [NumPorts*DataBits-1:0]   din_data,
  input  logic [NumPorts-1:0]            din_last,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [DataBits-1:0]            dout_data,
  output logic                           dout_last,
  output logic [PortIdxBits-1:0]         grant_id,
  output logic                           busy
);

  state_e                 r_state, w_state_nxt;
  logic [PortIdxBits-1:0] r_grant_id, r_last_grant, w_start, w_sel;
  logic [WeightBits-1:0]  r_credit, w_sel_weight, w_load_credit;
  logic                   w_found, w_xfer, w_others, w_release;

  assign w_start = next_port(r_last_grant, NumPorts);

  rr_priority_pick #(.NumPorts(NumPorts)) u_pick (
    .i_req   (din_valid),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_sel)
  );

  assign w_sel_weight  = weights[w_sel*WeightBits +: WeightBits];
  assign w_load_credit = (w_sel_weight == '0) ? WeightBits'(1) : w_sel_weight;
  assign w_others      = |(din_valid & ~(NumPorts'(1) << r_grant_id));
  assign grant_id      = r_grant_id;
  assign busy          = (r_state == GRANT);

  always_comb begin
    w_state_nxt = r_state;
    dout_valid  = 1'b0;
    dout_data   = '0;
    dout_last   = 1'b0;
    din_ready   = '0;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nxt = GRANT;
      end
      GRANT: begin
        dout_valid            = din_valid[r_grant_id];
        dout_data             = din_data[r_grant_id*DataBits +: DataBits];
        dout_last             = din_last[r_grant_id];
        din_ready[r_grant_id] = dout_ready;
        w_xfer                = dout_valid & dout_ready;
`ifdef STREAM_WRR_ARBITER_PKT_LOCK_EN
        w_release = w_xfer && dout_last && ((r_credit <= WeightBits'(1)) || w_others);
`else
        // Credit exhausted by this beat, or our port went quiet while someone else waits.
        w_release = (w_xfer && (r_credit <= WeightBits'(1))) || (!dout_valid && w_others);
`endif
        if (w_release) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= PortIdxBits'(NumPorts - 1);
      r_credit     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_grant_id <= w_sel;
        r_credit   <= w_load_credit;
      end
      if (w_xfer && r_credit != '0) r_credit <= r_credit - WeightBits'(1);
      if (w_release) r_last_grant <= r_grant_id;
    end
  end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Directed bench for stream_wrr_arbiter with an expected-beat queue and a decoupled output monitor.
module tb_stream_wrr_arbiter;

  localparam int NP = 4;
  localparam int DB = 32;
  localparam int WB = 4;

  typedef struct {
    int   port;
    int   seq;
    logic last;
    int   gap;
  } exp_t;

  logic             clk, rst;
  logic [NP*WB-1:0] weights;
  logic [NP-1:0]    din_valid, din_ready, din_last;
  logic [NP*DB-1:0] din_data;
  logic             dout_valid, dout_ready, dout_last;
  logic [DB-1:0]    dout_data;
  logic [2:0]       grant_id;
  logic             busy;

  logic [NP-1:0] src_en;
  int            cnt[NP];
  int            limit[NP];
  int            pl[NP] = '{1, 1, 1, 1};
  int            cyc, last_xfer_cyc, checks, errors;
  exp_t          exp_q[$];
  exp_t          mon_e;

  stream_wrr_arbiter #(.NumPorts(NP), .DataBits(DB), .WeightBits(WB)) dut (
    .clk        (clk),
    .rst        (rst),
    .weights    (weights),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_last   (din_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-port sources: payload tags port and beat number, last marks every pl[p]-th beat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) cnt[p] <= 0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (din_valid[p] && din_ready[p]) cnt[p] <= cnt[p] + 1;
    end
  end

  always_comb begin
    din_valid = '0;
    din_data  = '0;
    din_last  = '0;
    for (int p = 0; p < NP; p++) begin
      din_valid[p]        = src_en[p] && (cnt[p] < limit[p]);
      din_data[p*DB +: DB] = {8'(p), 24'(cnt[p])};
      din_last[p]         = (cnt[p] % pl[p]) == (pl[p] - 1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int port, input int seq, input int gap);
    exp_t e;
    e.port = port;
    e.seq  = seq;
    e.last = (seq % pl[port]) == (pl[port] - 1);
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got port %0d data %0h expected no beat", grant_id, dout_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_id", 64'(grant_id), 64'(mon_e.port));
        chk("data", 64'(dout_data), 64'({8'(mon_e.port), 24'(mon_e.seq)}));
        chk("last", 64'(dout_last), 64'(mon_e.last));
        if (mon_e.gap != 0) chk("beat_gap", 64'(cyc - last_xfer_cyc), 64'(mon_e.gap));
      end
      last_xfer_cyc = cyc;
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    src_en = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, 64'(dout_valid), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; last_xfer_cyc = 0;
    rst = 1'b0; dout_ready = 1'b1; weights = '0; src_en = '1;
    for (int p = 0; p < NP; p++) limit[p] = 100;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout_last", 64'(dout_last), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);

    // All weights 1: one beat per grant, one idle cycle between grants.
    do_reset();
    weights = {4'd1, 4'd1, 4'd1, 4'd1};
    pl = '{1, 1, 1, 1};
    limit = '{2, 2, 2, 2};
    for (int i = 0; i < 8; i++) push(i % 4, i / 4, (i == 0) ? 0 : 2);
    src_en = 4'hF;
    drain("rr_w1");

    // Weights 3,1,0,2 (port0..3): bursts of 3,1,1,2.
    do_reset();
    weights = {4'd2, 4'd0, 4'd1, 4'd3};
    pl = '{3, 1, 1, 2};
    limit = '{6, 2, 2, 4};
    push(0, 0, 0); push(0, 1, 1); push(0, 2, 1);
    push(1, 0, 2); push(2, 0, 2); push(3, 0, 2); push(3, 1, 1);
    push(0, 3, 2); push(0, 4, 1); push(0, 5, 1);
    push(1, 1, 2); push(2, 1, 2); push(3, 2, 2); push(3, 3, 1);
    src_en = 4'hF;
    drain("wrr");

    // Lone requester on port 2 is re-granted after every release.
    do_reset();
    weights = {4'd1, 4'd1, 4'd1, 4'd1};
    pl = '{1, 1, 1, 1};
    limit = '{0, 0, 5, 0};
    for (int i = 0; i < 5; i++) push(2, i, (i == 0) ? 0 : 2);
    src_en = 4'b0100;
    drain("lone_p2");

    // Back-pressure for 4 cycles mid-grant: credit must survive the stall.
    do_reset();
    weights = {4'd1, 4'd1, 4'd1, 4'd3};
    pl = '{3, 1, 1, 1};
    limit = '{3, 0, 0, 0};
    push(0, 0, 0); push(0, 1, 0); push(0, 2, 1);
    src_en = 4'b0001;
    wait_valid("stall");
    @(posedge clk);
    #1 dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_din_ready", 64'(din_ready), 64'd0);
      chk("stall_busy_grant", 64'({busy, grant_id}), 64'({1'b1, 3'd0}));
    end
    @(posedge clk);
    #1 dout_ready = 1'b1;
    drain("stall");

    // Reset during the second beat of a weight-2 grant.
    do_reset();
    weights = {4'd2, 4'd2, 4'd2, 4'd2};
    pl = '{2, 2, 1, 1};
    limit = '{2, 2, 0, 0};
    push(0, 0, 0);
    src_en = 4'b0011;
    wait_valid("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_mid_pre_valid", 64'(dout_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_mid_din_ready", 64'(din_ready), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_grant_id", 64'(grant_id), 64'd0);
    push(0, 0, 0); push(0, 1, 1); push(1, 0, 2); push(1, 1, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    drain("rst_mid");

    // Port 0 sends a 4-beat packet while port 1 waits, weight 1.
    do_reset();
    weights = {4'd1, 4'd1, 4'd1, 4'd1};
    pl = '{4, 4, 1, 1};
    limit = '{4, 4, 0, 0};
`ifdef STREAM_WRR_ARBITER_PKT_LOCK_EN
    push(0, 0, 0); push(0, 1, 1); push(0, 2, 1); push(0, 3, 1);
    push(1, 0, 2); push(1, 1, 1); push(1, 2, 1); push(1, 3, 1);
`else
    for (int i = 0; i < 8; i++) push(i % 2, i / 2, (i == 0) ? 0 : 2);
`endif
    src_en = 4'b0011;
    drain("pkt");

`ifndef STREAM_WRR_ARBITER_PKT_LOCK_EN
    // Granted port goes quiet with credit left while port 1 waits.
    do_reset();
    weights = {4'd1, 4'd1, 4'd1, 4'd3};
    pl = '{1, 1, 1, 1};
    limit = '{1, 1, 0, 0};
    push(0, 0, 0); push(1, 0, 3);
    src_en = 4'b0011;
    drain("idle_rel");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_wrr_arbiter.md
STREAM_WRR_ARBITER -- requirements
Module: stream_wrr_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 4, number of input streams (2..8).
REQ-002 SHALL have parameter DataBits, default 32, payload width.
REQ-003 SHALL have parameter WeightBits, default 4, per-port weight width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port weights  input  NumPorts*WeightBits  per-port weight; port i is at bits [i*WeightBits +: WeightBits].
REQ-007 SHALL have port din_valid  input  NumPorts  per-port valid.
REQ-008 SHALL have port din_ready  output  NumPorts  per-port ready.
REQ-009 SHALL have port din_data  input  NumPorts*DataBits  per-port payload.
REQ-010 SHALL have port din_last  input  NumPorts  per-port end-of-packet.
REQ-011 SHALL have port dout_valid / dout_ready / dout_data / dout_last  out/in/out/out  1/1/DataBits/1  merged stream.
REQ-012 SHALL have port grant_id  output  3  index of the granted port, registered.
REQ-013 SHALL have port busy  output  1  high while in GRANT.

Function
REQ-014 SHALL implement two states: IDLE and GRANT.
REQ-015 In IDLE, with any din_valid high, SHALL select the first valid port, searching from (last_grant+1) mod NumPorts upward with wrap, load credit with weights[sel], and enter GRANT on the next edge.
REQ-016 A weight of 0 SHALL be treated as 1.
REQ-017 In IDLE, dout_valid and all din_ready SHALL be 0.
REQ-018 In GRANT, dout_valid/data/last SHALL be combinational copies of din for grant_id; din_ready[grant_id] = dout_ready; all other din_ready = 0.
REQ-019 A transfer SHALL be dout_valid & dout_ready; each transfer SHALL decrement credit by 1, saturating at 0.
REQ-020 GRANT SHALL return to IDLE on the edge after the transfer that brings credit to 0 (release condition).
REQ-021 GRANT SHALL also return to IDLE if din_valid[grant_id] is low and some other din_valid is high (idle release); it SHALL stay in GRANT if no port is valid.
REQ-022 last_grant SHALL update to grant_id on each release; every release costs exactly one idle cycle before the next grant.
REQ-023 Simultaneous release and new requests SHALL be resolved only in the following IDLE cycle, never in the same cycle.
REQ-024 Weight changes SHALL take effect at the next credit load only.
REQ-025 The block SHALL add no storage and no pipeline stage to the data path (zero-latency pass-through while granted).

Reset
REQ-026 On rst, the block SHALL asynchronously enter IDLE with grant_id = 0, last_grant = NumPorts-1, credit = 0, busy = 0; dout_valid, dout_last, and din_ready SHALL therefore be 0.
REQ-027 rst asserted mid-packet SHALL drop the grant immediately; the partial packet is not completed.

Configuration
REQ-028 With STREAM_WRR_ARBITER_PKT_LOCK_EN defined, release (REQ-020, REQ-021) SHALL occur only on a transfer with dout_last = 1, once credit is 0 or the other ports are pending; packets are never interleaved.
REQ-029 Without STREAM_WRR_ARBITER_PKT_LOCK_EN, din_last SHALL be passed through only and SHALL not affect arbitration.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1) and the max-ports constant (8).
REQ-031 The round-robin search SHALL be one sub-module, rr_priority_pick, taking a request vector and a start index and returning found and index.

Verification
REQ-032 Weights all 1, ports 0-3 continuously valid, dout_ready = 1: grant order is 0,1,2,3,0; each grant is 1 beat followed by 1 idle cycle.
REQ-033 Weights {3,1,0,2}, all ports valid: beats per grant are 3,1,1,2, repeating in port order.
REQ-034 Only port 2 valid, weight 1, 5 beats: grant stays on 2 after release with no other requester; the sequence is IDLE, GRANT 2, and the data arrives intact.
REQ-035 dout_ready low for 4 cycles while granted: credit is unchanged, din_ready[grant_id] = 0, and no beats are lost.
REQ-036 With PKT_LOCK_EN defined, weight 1, port 0 sends a 4-beat packet while port 1 is valid: the grant switches to port 1 only after the beat with last = 1.
REQ-037 rst pulsed during the 2nd beat of a grant: outputs go 0 in the same cycle; after rst deasserts, the first grant goes to port 0.
